// File: rtl/windowed_regfile_pkg.sv
// Shared types and width helpers for the sliding-window register file.
package windowed_regfile_pkg;

    typedef enum logic [1:0] {
        FLT_NONE  = 2'd0,
        FLT_OVF   = 2'd1,
        FLT_UNF   = 2'd2,
        FLT_RANGE = 2'd3
    } fault_e;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_TOTAL_REGS  = 128;
    localparam int DEF_WIN_REGS    = 8;
    localparam int DEF_STACK_DEPTH = 8;

    // Frame-pointer width: enough bits to address every physical register.
    function automatic int fp_width(input int total_regs);
        return (total_regs > 1) ? $clog2(total_regs) : 1;
    endfunction

    // Window-relative select width.
    function automatic int sel_width(input int win_regs);
        return (win_regs > 1) ? $clog2(win_regs) : 1;
    endfunction

    // Stack level counts 0..depth inclusive, so one extra bit.
    function automatic int lvl_width(input int depth);
        return ((depth > 1) ? $clog2(depth) : 1) + 1;
    endfunction

endpackage

// File: rtl/windowed_regfile_fp_stack.sv
// LIFO of saved frame pointers; the top entry is readable combinationally so a
// return can restore the frame in the same cycle it is requested.
module fp_stack
    import windowed_regfile_pkg::*;
#(
    parameter int FP_W  = 7,
    parameter int DEPTH = 8,
    parameter int LVL_W = lvl_width(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [FP_W-1:0]  push_fp,
    output logic [FP_W-1:0]  top_fp,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int IDX_W = LVL_W - 1;

    logic [FP_W-1:0]  stack_mem [DEPTH];
    logic [LVL_W-1:0] level_reg;
    logic [LVL_W-1:0] top_lvl;

    assign full    = (level_reg == LVL_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign top_lvl = level_reg - LVL_W'(1);
    assign top_fp  = stack_mem[top_lvl[IDX_W-1:0]];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            level_reg <= '0;
        end else if (push && !full) begin
            level_reg <= level_reg + LVL_W'(1);
        end else if (pop && !empty) begin
            level_reg <= level_reg - LVL_W'(1);
        end
    end

    // Entries need no reset: the level counter gates every read.
    always_ff @(posedge Clock) begin
        if (push && !full) begin
            stack_mem[level_reg[IDX_W-1:0]] <= push_fp;
        end
    end

endmodule

// File: rtl/windowed_regfile.sv
// Sliding-window register file with CALL/RTN frame moves and sticky fault code.
// Optional same-cycle read forwarding is enabled by defining WINREG_BYPASS_EN.
module windowed_regfile
    import windowed_regfile_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TOTAL_REGS  = DEF_TOTAL_REGS,
    parameter int WIN_REGS    = DEF_WIN_REGS,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                              Clock,
    input  logic                              Reset,
    input  logic                              Rd_Wen,
    input  logic                              Rs_Wen,
    input  logic [sel_width(WIN_REGS)-1:0]    Rd_Sel,
    input  logic [sel_width(WIN_REGS)-1:0]    Rs_Sel,
    input  logic [sel_width(WIN_REGS)-1:0]    Rm_Sel,
    input  logic [DATA_W-1:0]                 Rd_Data,
    input  logic [DATA_W-1:0]                 Rs_Data,
    input  logic                              Call_Req,
    input  logic [sel_width(WIN_REGS):0]      Call_Offset,
    input  logic                              Rtn_Req,
    input  logic                              Fault_Clr,
    output logic [DATA_W-1:0]                 Rd_Out,
    output logic [DATA_W-1:0]                 Rs_Out,
    output logic [DATA_W-1:0]                 Rm_Out,
    output logic [WIN_REGS*DATA_W-1:0]        Window_Out,
    output logic [fp_width(TOTAL_REGS)-1:0]   FP_Out,
    output logic [lvl_width(STACK_DEPTH)-1:0] Stack_Level,
    output logic [1:0]                        Fault_Code
);

    localparam int FP_W  = fp_width(TOTAL_REGS);
    localparam int SEL_W = sel_width(WIN_REGS);
    localparam int LVL_W = lvl_width(STACK_DEPTH);

    logic [DATA_W-1:0] phys_reg [TOTAL_REGS];
    logic [FP_W-1:0]   fp_reg, fp_next;
    fault_e            fault_reg, fault_next, new_fault;

    logic [WIN_REGS-1:0][DATA_W-1:0] window_q;

    logic [FP_W-1:0] rd_addr, rs_addr, new_fp, stack_top;
    logic            do_push, do_pop, move, call_fits, fwd_ok;
    logic            stack_full, stack_empty;

    assign rd_addr   = fp_reg + FP_W'(Rd_Sel);
    assign rs_addr   = fp_reg + FP_W'(Rs_Sel);
    assign call_fits = (int'(fp_reg) + int'(Call_Offset) + WIN_REGS) <= TOTAL_REGS;

    fp_stack #(
        .FP_W  (FP_W),
        .DEPTH (STACK_DEPTH),
        .LVL_W (LVL_W)
    ) u_fp_stack (
        .Clock   (Clock),
        .Reset   (Reset),
        .push    (do_push),
        .pop     (do_pop),
        .push_fp (fp_reg),
        .top_fp  (stack_top),
        .full    (stack_full),
        .empty   (stack_empty),
        .level   (Stack_Level)
    );

    // Command decode: an overflow check takes precedence over the range check.
    always_comb begin
        new_fault = FLT_NONE;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        if (Call_Req && Rtn_Req) begin
            new_fault = FLT_RANGE;
        end else if (Call_Req) begin
            if (stack_full) begin
                new_fault = FLT_OVF;
            end else if (Call_Offset == '0 || !call_fits) begin
                new_fault = FLT_RANGE;
            end else begin
                do_push = 1'b1;
            end
        end else if (Rtn_Req) begin
            if (stack_empty) begin
                new_fault = FLT_UNF;
            end else begin
                do_pop = 1'b1;
            end
        end
        move    = do_push || do_pop;
        new_fp  = do_push ? (fp_reg + FP_W'(Call_Offset)) : stack_top;
        fp_next = move ? new_fp : fp_reg;
    end

    // Sticky fault: a clear in the same cycle as a new fault yields the new fault.
    always_comb begin
        fault_next = fault_reg;
        if (Fault_Clr) begin
            fault_next = FLT_NONE;
        end
        if (new_fault != FLT_NONE && (fault_reg == FLT_NONE || Fault_Clr)) begin
            fault_next = new_fault;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            fp_reg    <= '0;
            fault_reg <= FLT_NONE;
        end else begin
            fp_reg    <= fp_next;
            fault_reg <= fault_next;
        end
    end

    // Rs is written first so a same-address Rd write overrides it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < TOTAL_REGS; i++) begin
                phys_reg[i] <= '0;
            end
        end else begin
            if (Rs_Wen) begin
                phys_reg[rs_addr] <= Rs_Data;
            end
            if (Rd_Wen) begin
                phys_reg[rd_addr] <= Rd_Data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WIN_REGS; gi++) begin : g_slot
            logic [DATA_W-1:0] slot_reg, slot_next;
            logic [FP_W-1:0]   reload_addr;

            assign reload_addr = new_fp + FP_W'(gi);

            // On a frame move the slot reloads from the array, with same-cycle
            // writes (addressed in the old frame) forwarded by physical address.
            always_comb begin
                slot_next = slot_reg;
                if (move) begin
                    slot_next = phys_reg[reload_addr];
                    if (Rs_Wen && rs_addr == reload_addr) begin
                        slot_next = Rs_Data;
                    end
                    if (Rd_Wen && rd_addr == reload_addr) begin
                        slot_next = Rd_Data;
                    end
                end else begin
                    if (Rs_Wen && Rs_Sel == SEL_W'(gi)) begin
                        slot_next = Rs_Data;
                    end
                    if (Rd_Wen && Rd_Sel == SEL_W'(gi)) begin
                        slot_next = Rd_Data;
                    end
                end
            end

            always_ff @(posedge Clock) begin
                if (Reset) begin
                    slot_reg <= '0;
                end else begin
                    slot_reg <= slot_next;
                end
            end

            assign window_q[gi] = slot_reg;
        end
    endgenerate

`ifdef WINREG_BYPASS_EN
    assign fwd_ok = !move;
`else
    assign fwd_ok = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] read_slot(
        input logic [SEL_W-1:0]                sel,
        input logic [WIN_REGS-1:0][DATA_W-1:0] win,
        input logic                            fwd,
        input logic                            d_wen,
        input logic [SEL_W-1:0]                d_sel,
        input logic [DATA_W-1:0]               d_data,
        input logic                            s_wen,
        input logic [SEL_W-1:0]                s_sel,
        input logic [DATA_W-1:0]               s_data
    );
        logic [DATA_W-1:0] val;
        val = win[sel];
        if (fwd && d_wen && d_sel == sel) begin
            val = d_data;
        end else if (fwd && s_wen && s_sel == sel) begin
            val = s_data;
        end
        return val;
    endfunction

    assign Rd_Out = read_slot(Rd_Sel, window_q, fwd_ok, Rd_Wen, Rd_Sel, Rd_Data, Rs_Wen, Rs_Sel, Rs_Data);
    assign Rs_Out = read_slot(Rs_Sel, window_q, fwd_ok, Rd_Wen, Rd_Sel, Rd_Data, Rs_Wen, Rs_Sel, Rs_Data);
    assign Rm_Out = read_slot(Rm_Sel, window_q, fwd_ok, Rd_Wen, Rd_Sel, Rd_Data, Rs_Wen, Rs_Sel, Rs_Data);

    assign Window_Out = window_q;
    assign FP_Out     = fp_reg;
    assign Fault_Code = fault_reg;

endmodule

// File: doc/windowed_regfile.md
# windowed_regfile

Parametrised sliding-window register file for the CPU datapath. Holds TOTAL_REGS general registers, of which a WIN_REGS-wide window starting at an internal frame pointer (FP) is visible to the core. CALL and RTN move the window, and an internal frame-pointer stack remembers return frames. Illegal window moves raise a sticky fault. The block sits between decode/writeback and the execute stage.

## Interface
- DATA_W, 16, register width
- TOTAL_REGS, 128, physical registers; power of two
- WIN_REGS, 8, window size; power of two, ≤ TOTAL_REGS
- STACK_DEPTH, 8, saved-FP entries
- Clock  in  1  sole clock; all state updates on posedge
- Reset  in  1  synchronous, active-high
- Rd_Wen, Rs_Wen  in  1  write enables
- Rd_Sel, Rs_Sel, Rm_Sel  in  log2(WIN_REGS)  window-relative register selects
- Rd_Data, Rs_Data  in  DATA_W  write data
- Call_Req  in  1  push FP, advance window
- Call_Offset  in  log2(WIN_REGS)+1  window advance, legal range 1..WIN_REGS
- Rtn_Req  in  1  pop FP, restore window
- Fault_Clr  in  1  clear sticky fault
- Rd_Out, Rs_Out, Rm_Out  out  DATA_W  window[Rd_Sel/Rs_Sel/Rm_Sel]
- Window_Out  out  WIN_REGS*DATA_W  flattened window; slot i at bits [i*DATA_W +: DATA_W]
- FP_Out  out  log2(TOTAL_REGS)  current frame pointer
- Stack_Level  out  log2(STACK_DEPTH)+1  occupied stack entries
- Fault_Code  out  2  0 none, 1 stack overflow, 2 stack underflow, 3 range

## Operation
- Physical address of slot s = FP + s. Writes go to the physical array and to the window copy. Reads come from the window copy.
- Rd and Rs writes to the same slot in the same cycle: Rd wins.
- CALL is legal when:
  - the stack is not full,
  - Call_Offset ≠ 0, and
  - FP + Call_Offset + WIN_REGS ≤ TOTAL_REGS.
- Legal CALL:
  - push FP; FP ← FP + Call_Offset.
  - Window reloads from physical[newFP + i].
  - Same-cycle writes land at old-FP physical addresses. Where such an address lies inside the new window, the written value is forwarded into that new-window slot; it is not the stale array value.
- RTN is legal when the stack is not empty.
- Legal RTN:
  - FP ← popped value.
  - Window reloads from physical[popFP + i].
  - Same-cycle writes are forwarded under the same rule as CALL.
- Illegal command:
  - FP, stack and window are unchanged.
  - Same-cycle writes still commit.
  - Fault_Code is set.
- Call_Req and Rtn_Req in the same cycle: neither executes; Fault_Code ← 3.
- Fault is sticky: the first fault wins, and later faults do not overwrite it. Fault_Clr zeroes it. A fault and a Fault_Clr in the same cycle: the fault wins.

## Timing
- Reset: physical array, window, FP, Stack_Level and Fault_Code all zero; Rd_Out/Rs_Out/Rm_Out = 0.
- Write latency 1: data written at edge n is visible on the outputs after edge n.
- CALL/RTN latency 1: FP_Out, Window_Out and Stack_Level show the new frame after the command edge.
- Back-to-back commands are allowed every cycle; there is no busy signal.
- Read outputs are combinational from the window copy and Sel inputs.
- Reset asserted mid-sequence discards all frames; there is no partial restore.

## Configuration
- WINREG_BYPASS_EN defined: Rd_Out/Rs_Out/Rm_Out forward the same-cycle write data when the Sel matches a written slot. Rd has priority over Rs. Forwarding is suppressed in a cycle carrying a legal CALL/RTN.
- Not defined: read outputs show registered window contents only, so a write is first visible the cycle after it is written.
- Window_Out is never bypassed.

## Structure
- Package windowed_regfile_pkg:
  - fault_e enum (FLT_NONE, FLT_OVF, FLT_UNF, FLT_RANGE)
  - localparam helpers for FP width and select width
- Sub-module fp_stack:
  - parametrised LIFO of FP values, depth STACK_DEPTH
  - push/pop ports, full/empty flags, level output
  - simultaneous push and pop is never issued by the parent

## Test plan
- Reset, then write Rd_Sel=3 with 0xBEEF -> next cycle Rd_Out=0xBEEF, FP_Out=0, Window_Out slot 3 = 0xBEEF.
- CALL offset 4 with same-cycle Rd_Sel=5, data 0x1234 -> FP_Out=4; new slot 1 = 0x1234 via forwarding; Stack_Level=1. Then RTN -> FP_Out=0, slot 5 = 0x1234.
- Nine CALLs of offset 1 with STACK_DEPTH=8 -> 9th ignored, Fault_Code=1, FP_Out=8. Fault_Clr -> Fault_Code=0.
- RTN at reset state -> Fault_Code=2, FP unchanged. CALL with FP=120, offset 1 -> Fault_Code stays 2 (sticky), FP_Out=120.
- Call_Req and Rtn_Req together with Rs write 0x00AA to slot 0 -> Fault_Code=3, FP unchanged, slot 0 = 0x00AA.
- With WINREG_BYPASS_EN: Rd_Wen slot 2 = 0x5555 and Rm_Sel=2 -> Rm_Out=0x5555 in the same cycle. Without the macro -> old value that cycle, 0x5555 the next.
